// File: rtl/layer_generator.sv
// layer_generator: feeder for the top shift_layer. On a scroll request it draws
// a 7-column layer (platform map, block type, bonus map) from a free-running
// 16-bit LFSR and filters it for density and reachability. It then pulses
// load, then start, and stays busy until the scroll time plus a short guard
// has elapsed.
// Optional feature: define BONUS_GEN_EN to generate bonus positions; without
// it bonus_map_out is constant zero and no bonus logic exists.
module layer_generator #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_RETRY = 8,
  parameter int unsigned SCROLL_MS = 150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        module_en,
  input  logic        one_ms_tick,
  input  logic        scroll_req,
  output logic [0:6]  layer_map_out,
  output logic [0:6]  block_type_out,
  output logic [0:6]  bonus_map_out,
  output logic        load,
  output logic        start,
  output logic        busy,
  output logic [15:0] layer_count
);

  // Tick counter only needs to hold 0 .. SCROLL_MS-1.
  localparam int unsigned   TW         = (SCROLL_MS > 1) ? $clog2(SCROLL_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(SCROLL_MS - 1);
  localparam logic [3:0]    RETRY_LAST = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GUARD
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          lfsr_fb;
  logic [0:6]    prev_q, prev_d;
  logic [3:0]    retry_q, retry_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          guard_q, guard_d;
  logic [0:6]    map_q, map_d;
  logic [0:6]    bt_q, bt_d;
  logic [15:0]   count_q, count_d;
  logic          load_q, load_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;

  // Candidate evaluation signals
  logic [0:6]    cand;
  logic [0:6]    cand_bt;
  logic [0:6]    near;
  logic [0:8]    prev_pad;
  logic [2:0]    cand_pop;
  logic          cand_ok;
  logic          retry_done;

`ifdef BONUS_GEN_EN
  logic [0:6]    bonus_q, bonus_d;
  logic [0:6]    bonus_pick;
  logic          bonus_found;
  logic          bonus_roll;
`endif

  // Fibonacci LFSR, taps 16,14,13,11 counted from the output end; free-running.
  always_comb begin
    lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
  end

  // Previous map padded with empty columns so edge columns have no wrap-around
  // neighbours.
  assign prev_pad = {1'b0, prev_q, 1'b0};

  // Column i of the candidate is LFSR bit i; its cloud flag is LFSR bit 7+i.
  // A column is reachable when it or a direct neighbour held a block last layer.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_col
      assign cand[gi]    = lfsr_q[gi];
      assign cand_bt[gi] = lfsr_q[gi + 7] & lfsr_q[gi];
      assign near[gi]    = prev_pad[gi] | prev_pad[gi + 1] | prev_pad[gi + 2];
    end
  endgenerate

  // Density and reachability filter for the current candidate.
  always_comb begin
    cand_pop = 3'd0;
    for (int i = 0; i < 7; i++) begin
      cand_pop = cand_pop + {2'b00, cand[i]};
    end
    cand_ok    = (cand_pop >= 3'd2) && (cand_pop <= 3'd5) && (|(cand & near));
    retry_done = (retry_q == RETRY_LAST);
  end

`ifdef BONUS_GEN_EN
  // Bonus sits on the lowest-index block of the candidate, only on a lucky roll.
  always_comb begin
    bonus_pick  = 7'b0;
    bonus_found = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (cand[i] && !bonus_found) begin
        bonus_pick[i] = 1'b1;
        bonus_found   = 1'b1;
      end
    end
    bonus_roll = &lfsr_q[15:14];
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (scroll_req && module_en) state_d = S_GEN;
      S_GEN:   if (retry_done || cand_ok) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (one_ms_tick && (tick_q == TICK_LAST)) state_d = S_GUARD;
      S_GUARD: if (guard_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; pulses are decoded from the next state so
  // that every output comes straight from a flop.
  always_comb begin
    retry_d = retry_q;
    tick_d  = tick_q;
    guard_d = guard_q;
    prev_d  = prev_q;
    map_d   = map_q;
    bt_d    = bt_q;
    count_d = count_q;
`ifdef BONUS_GEN_EN
    bonus_d = bonus_q;
`endif
    case (state_q)
      S_IDLE: retry_d = 4'd0;
      S_GEN: begin
        if (retry_done) begin
          // Too many rejects: repeat the last layer, which is always reachable.
          map_d   = prev_q;
          bt_d    = 7'b0;
          count_d = count_q + 16'd1;
`ifdef BONUS_GEN_EN
          bonus_d = 7'b0;
`endif
        end else if (cand_ok) begin
          map_d   = cand;
          bt_d    = cand_bt;
          prev_d  = cand;
          count_d = count_q + 16'd1;
`ifdef BONUS_GEN_EN
          bonus_d = bonus_roll ? bonus_pick : 7'b0;
`endif
        end else begin
          retry_d = retry_q + 4'd1;
        end
      end
      S_START: tick_d = '0;
      S_WAIT: begin
        guard_d = 1'b0;
        if (one_ms_tick) tick_d = tick_q + TW'(1);
      end
      S_GUARD: guard_d = ~guard_q;
      default: ;
    endcase
    load_d  = (state_d == S_LOAD);
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
  end

  // LFSR register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_q <= 4'd0;
      tick_q  <= '0;
      guard_q <= 1'b0;
      prev_q  <= 7'h7F;
      map_q   <= 7'b0;
      bt_q    <= 7'b0;
      count_q <= 16'd0;
      load_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      retry_q <= retry_d;
      tick_q  <= tick_d;
      guard_q <= guard_d;
      prev_q  <= prev_d;
      map_q   <= map_d;
      bt_q    <= bt_d;
      count_q <= count_d;
      load_q  <= load_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BONUS_GEN_EN
  // Bonus map register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bonus_q <= 7'b0;
    end else begin
      bonus_q <= bonus_d;
    end
  end
  assign bonus_map_out = bonus_q;
`else
  assign bonus_map_out = 7'b0;
`endif

  assign layer_map_out  = map_q;
  assign block_type_out = bt_q;
  assign load           = load_q;
  assign start          = start_q;
  assign busy           = busy_q;
  assign layer_count    = count_q;

endmodule

// File: tb/tb_layer_generator.sv
// Directed bench for layer_generator: reset state, single scroll timing,
// tick-on-start, request held during a scroll, module disable, reset in the
// middle of a scroll and a run of back-to-back scrolls.
module tb_layer_generator;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          MAX_RETRY = 8;
  localparam int          SCROLL_MS = 150;

  logic        clk         = 1'b0;
  logic        rst         = 1'b1;
  logic        module_en   = 1'b1;
  logic        one_ms_tick = 1'b0;
  logic        scroll_req  = 1'b0;
  logic [0:6]  layer_map_out;
  logic [0:6]  block_type_out;
  logic [0:6]  bonus_map_out;
  logic        load;
  logic        start;
  logic        busy;
  logic [15:0] layer_count;

  int checks     = 0;
  int failures   = 0;
  int n_load     = 0;
  int n_start    = 0;
  int n_seq      = 0;
  int bonus_seen = 0;

  logic [15:0] m_lfsr;
  logic [0:6]  m_prev;
  logic [15:0] m_count;

  layer_generator #(
    .SEED      (SEED),
    .MAX_RETRY (MAX_RETRY),
    .SCROLL_MS (SCROLL_MS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .module_en      (module_en),
    .one_ms_tick    (one_ms_tick),
    .scroll_req     (scroll_req),
    .layer_map_out  (layer_map_out),
    .block_type_out (block_type_out),
    .bonus_map_out  (bonus_map_out),
    .load           (load),
    .start          (start),
    .busy           (busy),
    .layer_count    (layer_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] fb;
    fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
    return (l >> 1) | (fb << 15);
  endfunction

  function automatic int pop7(input logic [0:6] m);
    int n = 0;
    for (int i = 0; i < 7; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic logic [0:6] near_of(input logic [0:6] p);
    logic [0:6] n;
    for (int i = 0; i < 7; i++) begin
      n[i] = p[i];
      if (i > 0) n[i] = n[i] | p[i - 1];
      if (i < 6) n[i] = n[i] | p[i + 1];
    end
    return n;
  endfunction

  // Reference LFSR and pulse counters.
  always @(posedge clk) begin
    m_lfsr <= rst ? SEED : lfsr_step(m_lfsr);
    if (load)  n_load  <= n_load + 1;
    if (start) n_start <= n_start + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks candidates from the LFSR value seen in the first generate cycle.
  task automatic predict(input logic [15:0] l0, output int k,
                         output logic [0:6] e_map, output logic [0:6] e_bt,
                         output logic [0:6] e_bonus);
    logic [15:0] v;
    logic [0:6]  c;
    logic [0:6]  b;
    bit          done;
    v = l0; done = 0; k = 0;
    e_map = 7'b0; e_bt = 7'b0; e_bonus = 7'b0;
    for (int r = 0; r <= MAX_RETRY; r++) begin
      if (!done) begin
        if (r == MAX_RETRY) begin
          k = r; e_map = m_prev; e_bt = 7'b0; e_bonus = 7'b0; done = 1;
        end else begin
          for (int i = 0; i < 7; i++) begin
            c[i] = v[i];
            b[i] = v[7 + i] & v[i];
          end
          if (pop7(c) >= 2 && pop7(c) <= 5 && (c & near_of(m_prev)) != 7'b0) begin
            k = r; e_map = c; e_bt = b; e_bonus = 7'b0; done = 1;
`ifdef BONUS_GEN_EN
            if (v[15:14] == 2'b11) begin
              for (int i = 6; i >= 0; i--) if (c[i]) begin e_bonus = 7'b0; e_bonus[i] = 1'b1; end
            end
`endif
            m_prev = c;
          end
          v = lfsr_step(v);
        end
      end
    end
  endtask

  // One full scroll; called at a negedge while the DUT is idle.
  task automatic do_scroll(input int period, input bit tick_on_start,
                           input bit hold_req, input int abort_after);
    int          k;
    int          cnt;
    bit          aborted;
    logic [0:6]  emap, ebt, ebon, old_prev;
    aborted = 0;
    scroll_req = 1'b1;
    @(negedge clk);
    scroll_req = 1'b0;
    chk("busy_rise", 32'(busy), 32'(1));
    old_prev = m_prev;
    predict(m_lfsr, k, emap, ebt, ebon);
    m_count = m_count + 16'd1;
    n_seq++;
    cnt = 0;
    while (!load && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("load_latency", 32'(cnt), 32'(k + 1));
    chk("layer_map", 32'(layer_map_out), 32'(emap));
    chk("block_type", 32'(block_type_out), 32'(ebt));
    chk("bonus_map", 32'(bonus_map_out), 32'(ebon));
    chk("layer_count", 32'(layer_count), 32'(m_count));
    chk("start_during_load", 32'(start), 32'(0));
    chk("density", 32'((pop7(layer_map_out) >= 2 && pop7(layer_map_out) <= 5) || layer_map_out == old_prev), 32'(1));
    chk("adjacent", 32'((layer_map_out & near_of(old_prev)) != 7'b0), 32'(1));
    chk("bt_subset", 32'(block_type_out & ~layer_map_out), 32'(0));
    chk("bonus_subset", 32'(((bonus_map_out & ~layer_map_out) == 7'b0) && pop7(bonus_map_out) <= 1), 32'(1));
    if (bonus_map_out != 7'b0) bonus_seen++;
    @(negedge clk);
    chk("start_pulse", 32'(start), 32'(1));
    chk("load_fall", 32'(load), 32'(0));
    one_ms_tick = tick_on_start;
    @(negedge clk);
    one_ms_tick = 1'b0;
    chk("start_fall", 32'(start), 32'(0));
    if (hold_req) scroll_req = 1'b1;
    for (int t = 1; t <= SCROLL_MS; t++) begin
      repeat (period - 1) @(negedge clk);
      one_ms_tick = 1'b1;
      @(negedge clk);
      one_ms_tick = 1'b0;
      if (t == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_load", 32'(load), 32'(0));
        chk("abort_start", 32'(start), 32'(0));
        chk("abort_count", 32'(layer_count), 32'(0));
        chk("abort_map", 32'(layer_map_out), 32'(0));
        chk("abort_bt", 32'(block_type_out), 32'(0));
        m_prev  = 7'h7F;
        m_count = 16'd0;
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      scroll_req = 1'b0;
      chk("busy_guard1", 32'(busy), 32'(1));
      @(negedge clk);
      chk("busy_guard2", 32'(busy), 32'(1));
      @(negedge clk);
      chk("busy_fall", 32'(busy), 32'(0));
    end
  endtask

  initial begin
    m_prev  = 7'h7F;
    m_count = 16'd0;

    // Reset for two cycles, then idle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_map", 32'(layer_map_out), 32'(0));
    chk("rst_bt", 32'(block_type_out), 32'(0));
    chk("rst_bonus", 32'(bonus_map_out), 32'(0));
    chk("rst_load", 32'(load), 32'(0));
    chk("rst_start", 32'(start), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_count", 32'(layer_count), 32'(0));
    repeat (20) @(negedge clk);
    chk("idle_loads", 32'(n_load), 32'(0));
    chk("idle_starts", 32'(n_start), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));

    // Single scroll, tick every 10 cycles.
    do_scroll(10, 1'b0, 1'b0, 0);
    chk("single_count", 32'(layer_count), 32'(1));
    chk("single_loads", 32'(n_load), 32'(1));
    chk("single_starts", 32'(n_start), 32'(1));

    // Tick coinciding with the start cycle must be ignored.
    do_scroll(1, 1'b1, 1'b0, 0);

    // Request held through the scroll: no second sequence.
    do_scroll(1, 1'b0, 1'b1, 0);
    repeat (5) @(negedge clk);
    chk("hold_busy", 32'(busy), 32'(0));
    chk("hold_loads", 32'(n_load), 32'(n_seq));
    chk("hold_starts", 32'(n_start), 32'(n_seq));

    // Disabled module ignores requests.
    module_en  = 1'b0;
    scroll_req = 1'b1;
    repeat (10) @(negedge clk);
    chk("dis_busy", 32'(busy), 32'(0));
    scroll_req = 1'b0;
    module_en  = 1'b1;
    repeat (2) @(negedge clk);
    chk("dis_loads", 32'(n_load), 32'(n_seq));

    // Reset after 40 ticks, then a normal scroll.
    do_scroll(1, 1'b0, 1'b0, 40);
    repeat (3) @(negedge clk);
    chk("post_abort_busy", 32'(busy), 32'(0));
    do_scroll(1, 1'b0, 1'b0, 0);
    chk("post_abort_count", 32'(layer_count), 32'(1));

    // Back-to-back scrolls.
    for (int s = 0; s < 60; s++) do_scroll(1, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("total_loads", 32'(n_load), 32'(n_seq));
    chk("total_starts", 32'(n_start), 32'(n_seq));
    chk("final_count", 32'(layer_count), 32'(m_count));
`ifdef BONUS_GEN_EN
    chk("bonus_seen", 32'(bonus_seen > 0), 32'(1));
`else
    chk("bonus_none", 32'(bonus_seen), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
